switch_debouncer: RTL

//   Input conditioning stage for the board slide switches (enable, select0, select1).

---
 rtl/switch_debouncer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer
// Conditions the raw board slide switches before they reach the LED blinker.
// Each channel has a 2-FF synchroniser followed by a small debounce FSM with a
// persistence counter. The FSM accepts a new level only after it has been seen
// at the synchroniser output for DEBOUNCE_COUNT consecutive clocks. When a
// level is accepted, the channel emits a one-cycle change pulse.
//
// Timing: a level held stable at i_sw_raw shows up on o_sw_clean DEBOUNCE_COUNT+2
// rising edges after it is first sampled. Two of those edges are spent in the
// synchroniser and DEBOUNCE_COUNT in the counter. o_sw_changed rises in the
// same cycle that o_sw_clean takes its new value. Every output comes straight
// from a flop.

module switch_debouncer #(
  parameter int NUM_SW         = 3,
  parameter int DEBOUNCE_COUNT = 500_000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_SW-1:0] i_sw_raw,
  output logic [NUM_SW-1:0] o_sw_clean,
  output logic [NUM_SW-1:0] o_sw_changed
);

  // Counter width follows from the debounce period. It only has to reach
  // DEBOUNCE_COUNT-1, so $clog2 gives exactly enough bits and the counter
  // can never wrap.
  localparam int               CNT_W    = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // MATCH     : synchronised level equals the accepted level; the counter idles at 0.
  // COUNTING  : synchronised level differs; the counter measures how long it persists.
  typedef enum logic {
    ST_MATCH    = 1'b0,
    ST_COUNTING = 1'b1
  } deb_state_e;

  // Synchroniser stages
  logic [NUM_SW-1:0] sync1_q;
  logic [NUM_SW-1:0] sync2_q;

  // Per-channel debounce state
  deb_state_e        state_q  [NUM_SW];
  deb_state_e        state_d  [NUM_SW];
  logic [CNT_W-1:0]  count_q  [NUM_SW];
  logic [CNT_W-1:0]  count_d  [NUM_SW];
  logic [NUM_SW-1:0] clean_q;
  logic [NUM_SW-1:0] clean_d;
  logic [NUM_SW-1:0] changed_q;
  logic [NUM_SW-1:0] changed_d;

  // Two-flop synchroniser per channel; only sync2_q is allowed to feed the FSMs.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; with '=' sync2_q would grab the new
    // sync1_q and the two stages would collapse into one.
    if (i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_sw_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce state registers: FSM state, persistence counters, accepted level and pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: count_q is an array of ordinary flops, not a RAM, so it can take
      // a reset. Resetting it here means a change that was half-way counted
      // when reset arrived is forgotten completely.
      for (int k = 0; k < NUM_SW; k++) begin
        state_q[k] <= ST_MATCH;
        count_q[k] <= '0;
      end
      clean_q   <= '0;
      changed_q <= '0;
    end else begin
      for (int k = 0; k < NUM_SW; k++) begin
        state_q[k] <= state_d[k];
        count_q[k] <= count_d[k];
      end
      clean_q   <= clean_d;
      changed_q <= changed_d;
    end
  end

  // Next-state logic per channel: advance the counter, accept the level at
  // terminal count, and classify the following cycle.
  always_comb begin
    for (int k = 0; k < NUM_SW; k++) begin
      // NOTE: every output of this block gets a default before any branch.
      // A path that left one unassigned would infer a latch.
      state_d[k]   = state_q[k];
      count_d[k]   = count_q[k];
      clean_d[k]   = clean_q[k];
      changed_d[k] = 1'b0;

      unique case (state_q[k])
        ST_MATCH: begin
          count_d[k] = '0;
        end
        ST_COUNTING: begin
          if (count_q[k] == CNT_LAST) begin
            clean_d[k]   = sync2_q[k];
            count_d[k]   = '0;
            changed_d[k] = 1'b1;
          end else begin
            count_d[k] = count_q[k] + CNT_ONE;
          end
        end
        default: begin
          count_d[k] = '0;
        end
      endcase

      // sync1_q is what sync2_q holds after this edge. Comparing it with the
      // next accepted level therefore gives the state for the next cycle.
      // This keeps state_q equal to (sync2_q != clean_q) at all times. When
      // sync2_q drops back to the accepted level, the channel is in MATCH on
      // that edge and the counter clears, even at terminal count.
      state_d[k] = (sync1_q[k] == clean_d[k]) ? ST_MATCH : ST_COUNTING;
    end
  end

  assign o_sw_clean   = clean_q;
  assign o_sw_changed = changed_q;

endmodule
